// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: opcode constants, fetch FSM encoding and the
// instruction-queue entry payload.
package cpu_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // IDLE: free to issue; WAIT: one request outstanding;
  // DISCARD: outstanding request was squashed, its response is dropped.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// In-order first-word-fall-through queue of fetched instructions.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write push_data_i at the tail (accepted when not full, or full with pop)
//   push_data_i   entry to write
//   pop_i         advance head (ignored when empty)
//   clear_i       drop all entries, pointers back to 0; overrides push/pop
//   head_o        entry at the head, read straight from storage
//   count_o       occupancy, $clog2(DEPTH)+1 bits
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
module instr_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  iq_entry_t                  push_data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output iq_entry_t                  head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer/count next state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one icache request in
// flight, statically predicts JAL/backward branches taken and queues fetched
// instructions for the decoder. Redirects flush the queue and squash any
// in-flight response.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   redirect_en/redirect_pc  flush and restart fetch at redirect_pc
//   icache_idle              icache can take a request
//   icache_out_en            response valid pulse with icache_instr/icache_c_instr
//   icache_get_en            request pulse (combinational)
//   icache_addr              request address = pc[ADDR_W-1:0] (combinational)
//   iq_ready                 decoder consumes the head entry
//   iq_valid, iq_*           head entry of the instruction queue
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  input  logic              icache_idle,
  input  logic              icache_out_en,
  input  logic [31:0]       icache_instr,
  input  logic              icache_c_instr,
  output logic              icache_get_en,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic              iq_ready,
  output logic              iq_valid,
  output logic [31:0]       iq_instr,
  output logic [31:0]       iq_pc,
  output logic              iq_c,
  output logic              iq_pred_taken,
  output logic [31:0]       iq_pred_pc
);

  localparam int unsigned CNT_W = $clog2(IQ_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] iq_count;
  logic             iq_full, iq_empty;
  logic             resp_push;
  iq_entry_t        push_entry, head;
  logic [6:0]       opc;
  logic [31:0]      imm_j, imm_b, seq_pc, pred_pc;
  logic             pred_taken;
  logic             unused_full;

  // Occupancy check is done on count; full stays a queue output for other users.
  assign unused_full = iq_full;

  // The room check guarantees a queue slot for the single outstanding response.
  assign icache_get_en = !rst && (state_q == S_IDLE) && icache_idle && !redirect_en
                         && (iq_count < CNT_W'(IQ_DEPTH));
  assign icache_addr   = pc_q[ADDR_W-1:0];

  assign resp_push = (state_q == S_WAIT) && icache_out_en && !redirect_en;

  // Static predictor on the returning instruction.
  always_comb begin
    opc        = icache_instr[6:0];
    imm_j      = {{12{icache_instr[31]}}, icache_instr[19:12], icache_instr[20],
                  icache_instr[30:21], 1'b0};
    imm_b      = {{20{icache_instr[31]}}, icache_instr[7], icache_instr[30:25],
                  icache_instr[11:8], 1'b0};
    seq_pc     = pc_q + (icache_c_instr ? 32'd2 : 32'd4);
    pred_taken = 1'b0;
    pred_pc    = seq_pc;
    if (opc == OPC_JAL) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + imm_j;
    end else if (opc == OPC_BRANCH) begin
      pred_taken = imm_b[31];
      if (imm_b[31]) pred_pc = pc_q + imm_b;
    end
  end

  always_comb begin
    push_entry.instr      = icache_instr;
    push_entry.pc         = pc_q;
    push_entry.c          = icache_c_instr;
    push_entry.pred_taken = pred_taken;
    push_entry.pred_pc    = pred_pc;
  end

  // Next-state logic; a redirect overrides any response landing the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:    if (icache_get_en) state_d = S_WAIT;
      S_WAIT:    begin
        if (icache_out_en)    state_d = S_IDLE;
        else if (redirect_en) state_d = S_DISCARD;
      end
      S_DISCARD: if (icache_out_en) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (redirect_en)    pc_d = redirect_pc;
    else if (resp_push) pc_d = pred_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  instr_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_iq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (resp_push),
    .push_data_i(push_entry),
    .pop_i      (iq_ready),
    .clear_i    (redirect_en),
    .head_o     (head),
    .count_o    (iq_count),
    .full_o     (iq_full),
    .empty_o    (iq_empty)
  );

  assign iq_valid      = !iq_empty;
  assign iq_instr      = head.instr;
  assign iq_pc         = head.pc;
  assign iq_c          = head.c;
  assign iq_pred_taken = head.pred_taken;
  assign iq_pred_pc    = head.pred_pc;

endmodule
